// File: rtl/led7seg_pkg.sv
// rtl/led7seg_pkg.sv - shared codes, segment patterns and helpers for led7seg_scan
package led7seg_pkg;

    // Non-digit BCD codes held in the display register.
    localparam logic [3:0] BCD_BLANK = 4'hA;
    localparam logic [3:0] BCD_DASH  = 4'hF;

    typedef enum logic {
        CONV_IDLE = 1'b0,
        CONV_RUN  = 1'b1
    } conv_state_e;

    // Segment pattern {g,f,e,d,c,b,a}, active-high. Codes 10..14 are blank.
    function automatic logic [6:0] seg_pattern(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            BCD_DASH: pat = 7'h40;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // 10^n; n is at most 8, so the result fits comfortably in 32 bits.
    function automatic logic [31:0] pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/led7seg_bin2bcd.sv
// rtl/led7seg_bin2bcd.sv - sequential double-dabble binary to BCD converter
// Ports: start/data load a value when ready; done pulses (combinationally) in the
// cycle whose rising edge performs the last iteration, with bcd presenting that
// iteration's result; ovf flags data >= 10^DIGITS.
module led7seg_bin2bcd
    import led7seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      data,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int          CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [31:0] LIMIT = pow10(DIGITS);

    conv_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;
    logic [4*DIGITS-1:0]  bcd_adj;
    logic [4*DIGITS-1:0]  bcd_step;

    // One double-dabble iteration: add 3 to nibbles >= 5, then shift in the next MSB.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_step = {bcd_adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        case (state_q)
            CONV_IDLE: begin
                if (start) begin
                    state_d = CONV_RUN;
                    cnt_d   = CW'(WIDTH - 1);
                    shift_d = data;
                    bcd_d   = '0;
                    ovf_d   = (32'(data) >= LIMIT);
                end
            end
            CONV_RUN: begin
                bcd_d   = bcd_step;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = CONV_IDLE;
                end
            end
            default: state_d = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CONV_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready = (state_q == CONV_IDLE);
    assign done  = (state_q == CONV_RUN) && (cnt_q == '0);
    assign bcd   = bcd_step;
    assign ovf   = ovf_q;

endmodule

// File: rtl/led7seg_scan.sv
// rtl/led7seg_scan.sv - multiplexed N-digit seven-segment driver with BCD conversion
// Ports: data/valid/ready load a binary value (dp sampled with it); en blanks outputs;
// an is the one-hot digit enable (bit 0 = LSD); seg is {dp,g,f,e,d,c,b,a}, active-high.
// Optional feature: define LED7SEG_LZB_EN for leading-zero blanking at commit.
module led7seg_scan
    import led7seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int WIDTH    = 14,
    parameter int SCAN_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  data,
    input  logic              valid,
    output logic              ready,
    input  logic              en,
    input  logic [DIGITS-1:0] dp,
    output logic [DIGITS-1:0] an,
    output logic [7:0]        seg
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW = $clog2(SCAN_DIV);

    logic                      load;
    logic                      conv_done;
    logic [4*DIGITS-1:0]       conv_bcd;
    logic                      conv_ovf;

    logic [DIGITS-1:0][3:0]    disp_q, disp_d, commit_val;
    logic [DIGITS-1:0]         dp_q, dp_d;
    logic [SW-1:0]             scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [DIGITS-1:0]         an_q, an_d;
    logic [7:0]                seg_q, seg_d;

    assign load = valid && ready;

    led7seg_bin2bcd #(
        .DIGITS (DIGITS),
        .WIDTH  (WIDTH)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (load),
        .data  (data),
        .ready (ready),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

`ifdef LED7SEG_LZB_EN
    logic lead;
`endif

    // Value written to the display register at commit.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            commit_val[i] = conv_ovf ? BCD_DASH : conv_bcd[4*i +: 4];
        end
`ifdef LED7SEG_LZB_EN
        // Walk down from the top digit; digit 0 always stays visible.
        lead = !conv_ovf;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (commit_val[i] == 4'd0)) begin
                commit_val[i] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
`endif
    end

    always_comb begin
        disp_d = conv_done ? commit_val : disp_q;
        dp_d   = load ? dp : dp_q;

        scan_cnt_d = scan_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        an_d  = '0;
        seg_d = '0;
        if (en) begin
            an_d  = DIGITS'(1) << idx_q;
            seg_d = {dp_q[idx_q], seg_pattern(disp_q[idx_q])};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q     <= '0;
            dp_q       <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            an_q       <= '0;
            seg_q      <= '0;
        end else begin
            disp_q     <= disp_d;
            dp_q       <= dp_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_led7seg_scan.sv
// tb/tb_led7seg_scan.sv - self-checking bench for led7seg_scan (DIGITS=4, WIDTH=14, SCAN_DIV=4)
module tb_led7seg_scan;

    localparam int DIGITS   = 4;
    localparam int WIDTH    = 14;
    localparam int SCAN_DIV = 4;

    logic              clk;
    logic              rst_n;
    logic [WIDTH-1:0]  data;
    logic              valid;
    logic              ready;
    logic              en;
    logic [DIGITS-1:0] dp;
    logic [DIGITS-1:0] an;
    logic [7:0]        seg;

    int tests;
    int fails;
    int cyc;

    led7seg_scan #(
        .DIGITS   (DIGITS),
        .WIDTH    (WIDTH),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .en    (en),
        .dp    (dp),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] digit_pat(input int d);
        case (d)
            0: return 32'h3F;
            1: return 32'h06;
            2: return 32'h5B;
            3: return 32'h4F;
            4: return 32'h66;
            5: return 32'h6D;
            6: return 32'h7D;
            7: return 32'h07;
            8: return 32'h7F;
            9: return 32'h6F;
            default: return 32'h00;
        endcase
    endfunction

    // Expected seg for digit k after value v with dp mask dpv has been committed.
    function automatic logic [31:0] exp_seg(input int v, input logic [3:0] dpv, input int k);
        int          p;
        logic [31:0] pat;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (v >= 10000) begin
            pat = 32'h40;
        end else begin
            pat = digit_pat((v / p) % 10);
`ifdef LED7SEG_LZB_EN
            if (k > 0 && v < p) pat = 32'h00;
`endif
        end
        return pat | (dpv[k] ? 32'h80 : 32'h00);
    endfunction

    function automatic logic [31:0] exp_an_now();
        return 32'(1) << (((cyc - 1) / SCAN_DIV) % DIGITS);
    endfunction

    task automatic start_load(input int v, input logic [3:0] dpv);
        @(negedge clk);
        chk("ready_before_load", ready, 1);
        data  = WIDTH'(v);
        dp    = dpv;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // raw_zero: display register holds reset zeros (never committed), so all digits read 0x3F.
    task automatic check_digits(input int v, input logic [3:0] dpv, input bit raw_zero);
        int n;
        @(posedge clk);
        for (int k = 0; k < DIGITS; k++) begin
            n = 0;
            @(negedge clk);
            while (an !== 4'(1 << k) && n < 40) begin
                n++;
                @(negedge clk);
            end
            chk($sformatf("an_digit%0d_v%0d", k, v), an, 32'(1) << k);
            chk($sformatf("seg_digit%0d_v%0d", k, v), seg,
                raw_zero ? 32'h3F : exp_seg(v, dpv, k));
        end
    endtask

    task automatic load_and_check(input int v, input logic [3:0] dpv);
        int n;
        start_load(v, dpv);
        wait_ready(n);
        chk($sformatf("ready_low_cycles_v%0d", v), n, 14);
        check_digits(v, dpv, 1'b0);
    endtask

    initial begin
        int          n;
        int          va;
        int          vb;
        logic [3:0]  dpr;

        tests = 0;
        fails = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        data  = '0;
        valid = 1'b0;
        en    = 1'b1;
        dp    = '0;

        #1;
        chk("reset_ready", ready, 1);
        chk("reset_an", an, 0);
        chk("reset_seg", seg, 0);

        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle scan: every digit shows 0 and each is lit SCAN_DIV cycles in order.
        for (int i = 0; i < 2 * DIGITS * SCAN_DIV; i++) begin
            @(negedge clk);
            chk("scan_an", an, exp_an_now());
            chk("scan_seg", seg, 32'h3F);
        end

        load_and_check(1234, 4'b0000);
        load_and_check(10000, 4'b0000);
        load_and_check(9999, 4'b0101);
        load_and_check(7, 4'b0000);
        load_and_check(0, 4'b1000);
        load_and_check(16383, 4'b0000);

        for (int r = 0; r < 6; r++) begin
            va  = int'($urandom_range(0, 16383));
            dpr = 4'($urandom_range(0, 15));
            load_and_check(va, dpr);
        end

        // valid asserted during a conversion must be ignored.
        va = int'($urandom_range(0, 9999));
        vb = (va + 1 + int'($urandom_range(0, 5000))) % 10000;
        start_load(va, 4'b0010);
        @(negedge clk);
        data  = WIDTH'(vb);
        dp    = 4'b0100;
        valid = 1'b1;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        wait_ready(n);
        check_digits(va, 4'b0010, 1'b0);

        // Reset in mid-conversion: ready returns at once, display goes to zeros.
        start_load(4321, 4'b1111);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_ready", ready, 1);
        chk("midreset_an", an, 0);
        chk("midreset_seg", seg, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_digits(0, 4'b0000, 1'b1);

        // Display disable: outputs dark, scan keeps running underneath.
        load_and_check(5678, 4'b0000);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("disabled_an", an, 0);
            chk("disabled_seg", seg, 0);
            @(negedge clk);
        end
        en = 1'b1;
        for (int i = 0; i < DIGITS * SCAN_DIV; i++) begin
            @(negedge clk);
            chk("resume_an", an, exp_an_now());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
